// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 5-stage RV32I core.
// Single-outstanding imem requests, one-entry skid buffer for responses that arrive during StallD.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic        drop_q, drop_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;

    logic        hs;
    logic        deliver_mem;
    logic        deliver_buf;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pcf_q + 32'd4;
    assign hs       = imem_req_valid & imem_req_ready;

    // Request side is a function of registered state and StallF only.
    always_comb begin
        imem_req_valid = (state_q == S_REQ) && !StallF;
        imem_addr      = pcf_q;
    end

    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        buf_d       = buf_q;
        deliver_mem = 1'b0;
        deliver_buf = 1'b0;
        case (state_q)
            S_REQ: begin
                if (hs) begin
                    state_d = S_WAIT;
                    if (PCSrcE) drop_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                    drop_d  = 1'b0;
                    if (!drop_q && !PCSrcE) begin
                        if (StallD) begin
                            state_d = S_HOLD;
                            buf_d   = imem_rdata;
                        end else begin
                            deliver_mem = 1'b1;
                        end
                    end
                end else if (PCSrcE) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (PCSrcE) begin
                    state_d = S_REQ;
                end else if (!StallD) begin
                    state_d     = S_REQ;
                    deliver_buf = 1'b1;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // A delivered instruction has left fetch, so PC advances even if StallF is up.
    always_comb begin
        pcf_d = pcf_q;
        if (PCSrcE)                         pcf_d = PCTargetE;
        else if (deliver_mem || deliver_buf) pcf_d = pc_plus4;
    end

    always_comb begin
        instr_d = NOP_INSTR;
        pcd_d   = 32'd0;
        pcp4_d  = 32'd0;
        valid_d = 1'b0;
        if (FlushD || PCSrcE) begin
            valid_d = 1'b0;
        end else if (StallD) begin
            instr_d = instr_q;
            pcd_d   = pcd_q;
            pcp4_d  = pcp4_q;
            valid_d = valid_q;
        end else if (deliver_mem || deliver_buf) begin
            instr_d = deliver_mem ? imem_rdata : buf_q;
            pcd_d   = pcf_q;
            pcp4_d  = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            pcf_q   <= RESET_PC;
            drop_q  <= 1'b0;
            buf_q   <= 32'd0;
            instr_q <= NOP_INSTR;
            pcd_q   <= 32'd0;
            pcp4_q  <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pcf_q   <= pcf_d;
            drop_q  <= drop_d;
            buf_q   <= buf_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
        end
    end

    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcp4_q;
    assign ValidD   = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: transaction-level fetch model plus a latency-randomized imem responder.
module tb_if_stage;

    localparam int NCYC = 3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req_valid, imem_req_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    if_stage dut (
        .clk(clk), .rst_n(rst_n),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: fetch PC, one outstanding request (possibly stale), one parked response.
    logic [31:0] m_pc;
    logic        m_out, m_stale, m_buf_v;
    logic [31:0] m_buf_i, m_buf_pc;
    logic        e_valid;
    logic [31:0] e_instr, e_pc, e_pc4;

    // Memory responder
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%08h want=%08h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_out = 0; m_stale = 0; m_buf_v = 0; m_buf_i = 0; m_buf_pc = 0;
        e_valid = 0; e_instr = 32'h13; e_pc = 0; e_pc4 = 0;
    endtask

    task automatic model_step();
        logic hs_m, resp, dlv;
        logic [31:0] d_instr, d_pc;
        logic n_out, n_stale, nb_v;
        logic [31:0] nb_i, nb_pc;
        hs_m = !m_out && !m_buf_v && !StallF && imem_req_ready;
        resp = m_out && imem_rvalid;
        dlv = 0; d_instr = 0; d_pc = 0;
        nb_v = m_buf_v; nb_i = m_buf_i; nb_pc = m_buf_pc;
        n_out = m_out; n_stale = m_stale;
        if (hs_m) begin n_out = 1; n_stale = 0; end
        if (resp) begin
            n_out = 0; n_stale = 0;
            if (!m_stale && !PCSrcE) begin
                if (StallD) begin nb_v = 1; nb_i = imem_rdata; nb_pc = m_pc; end
                else begin dlv = 1; d_instr = imem_rdata; d_pc = m_pc; end
            end
        end
        if (m_buf_v && !PCSrcE && !StallD) begin
            dlv = 1; d_instr = m_buf_i; d_pc = m_buf_pc; nb_v = 0;
        end
        if (PCSrcE) begin
            nb_v = 0;
            if (hs_m || (m_out && !resp)) n_stale = 1;
        end
        if (FlushD || PCSrcE) begin
            e_valid = 0; e_instr = 32'h13; e_pc = 0; e_pc4 = 0;
        end else if (!StallD) begin
            if (dlv) begin e_valid = 1; e_instr = d_instr; e_pc = d_pc; e_pc4 = d_pc + 32'd4; end
            else begin e_valid = 0; e_instr = 32'h13; e_pc = 0; e_pc4 = 0; end
        end
        if (PCSrcE)   m_pc = PCTargetE;
        else if (dlv) m_pc = d_pc + 32'd4;
        m_out = n_out; m_stale = n_stale;
        m_buf_v = nb_v; m_buf_i = nb_i; m_buf_pc = nb_pc;
    endtask

    initial begin
        logic did_rst;
        logic hs;
        int   r;
        did_rst = 0;
        rst_n = 0; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0;
        imem_req_ready = 0; imem_rvalid = 0; imem_rdata = 0;
        mem_busy = 0; mem_cnt = 0; mem_addr = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", {31'd0, ValidD}, 32'd0);
        chk("rst_instr", InstrD, 32'h0000_0013);
        chk("rst_pcd",   PCD, 32'd0);
        chk("rst_pcp4",  PCPlus4D, 32'd0);
        chk("rst_addr",  imem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1;

        for (cyc = 0; cyc < NCYC; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (!rst_n) rst_n = 1;

            if (cyc < 20) begin
                StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0;
            end else begin
                StallF = ($urandom_range(0, 9) < 2);
                StallD = ($urandom_range(0, 9) < 2);
                FlushD = ($urandom_range(0, 19) == 0);
                PCSrcE = ($urandom_range(0, 11) == 0);
                r = $urandom_range(0, 3);
                PCTargetE = (r == 0) ? 32'hFFFF_FFFC : (r == 1) ? 32'h100 :
                            {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            end
            imem_rvalid = mem_busy && (mem_cnt == 0);
            if (imem_rvalid && cyc < 20) imem_rdata = mem_addr | 32'hA000_0000;
            else                          imem_rdata = $urandom;
            imem_req_ready = !mem_busy && (cyc < 20 || $urandom_range(0, 9) < 7);

            if (!did_rst && cyc >= 600 && mem_busy && mem_cnt > 0) begin
                rst_n = 0; did_rst = 1;
                model_reset();
            end
            #1;

            chk("ValidD",   {31'd0, ValidD}, {31'd0, e_valid});
            chk("InstrD",   InstrD, e_instr);
            chk("PCD",      PCD, e_pc);
            chk("PCPlus4D", PCPlus4D, e_pc4);
            chk("req_valid", {31'd0, imem_req_valid}, {31'd0, (!m_out && !m_buf_v && !StallF)});
            chk("imem_addr", imem_addr, m_pc);

            if (!rst_n) begin
                chk("midrst_addr",  imem_addr, 32'd0);
                chk("midrst_valid", {31'd0, ValidD}, 32'd0);
            end
            case (cyc)
                2: begin chk("z_pcd0", PCD, 32'h0); chk("z_ins0", InstrD, 32'hA000_0000);
                         chk("z_addr4", imem_addr, 32'h4); end
                3: begin chk("z_bub", {31'd0, ValidD}, 32'd0); chk("z_bubi", InstrD, 32'h13); end
                4: begin chk("z_pcd4", PCD, 32'h4); chk("z_ins4", InstrD, 32'hA000_0004); end
                6: begin chk("z_pcd8", PCD, 32'h8); chk("z_p4_8", PCPlus4D, 32'hC); end
                14: begin chk("w_pcd", PCD, 32'h10); chk("w_ins", InstrD, 32'hA000_0010);
                          chk("w_addr", imem_addr, 32'h14); end
                default: ;
            endcase
            if (cyc >= 9 && cyc <= 13) begin
                chk("w_reqv", {31'd0, imem_req_valid}, 32'd0);
                chk("w_valid", {31'd0, ValidD}, 32'd0);
                chk("w_hold", imem_addr, 32'h10);
            end

            if (rst_n) model_step();

            hs = rst_n && imem_req_valid && imem_req_ready;
            if (imem_rvalid)   mem_busy = 0;
            else if (mem_busy) mem_cnt--;
            if (hs) begin
                mem_busy = 1;
                mem_addr = imem_addr;
                if (cyc < 8)       mem_cnt = 0;
                else if (cyc < 20) mem_cnt = 4;
                else               mem_cnt = $urandom_range(0, 3);
            end
        end
        chk("midrst_seen", {31'd0, did_rst}, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
